key_conditioner: RTL and testbench

Front-end input stage of the electronic piano. It synchronises and debounces the seven raw note buttons and the two pitch switches. It arbitrates simultaneous presses down to a single latched note and drives a clean one-hot `btn[6:0]` plus a debounced `sw[1:0]` to the LCD text stage and the tone generator downstream. It also emits single-cycle press/release strobes for event-driven consumers.

---
 rtl/keycond_pkg.sv | 29 ++
 rtl/key_conditioner_debounce_bit.sv | 42 ++++
 rtl/key_conditioner.sv | 90 +++++++++
 tb/tb_key_conditioner.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/keycond_pkg.sv
// Shared constants, arbiter state type and priority helper for the key conditioner.
package keycond_pkg;

    localparam int NUM_NOTES = 7;
    localparam logic [2:0] NOTE_NONE = 3'd7;

    // Bit positions of each note within key_raw / btn.
    localparam int DO = 6;
    localparam int RI = 5;
    localparam int MI = 4;
    localparam int FA = 3;
    localparam int SO = 2;
    localparam int LA = 1;
    localparam int XI = 0;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } arb_state_t;

    // Position of the highest set bit; later iterations win, so DO has top priority.
    function automatic logic [2:0] top_bit(input logic [NUM_NOTES-1:0] v);
        top_bit = 3'd0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (v[i]) top_bit = 3'(i);
        end
    endfunction

endpackage

// File: rtl/key_conditioner_debounce_bit.sv
// Two-flop synchroniser followed by a counting debouncer for one asynchronous input.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync0 <= din;
            sync1 <= sync0;
            if (sync1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign dout = stable;

endmodule

// File: rtl/key_conditioner.sv
// Debounces note keys and pitch switches, latches one note at a time with press/release strobes.
// Define KEYCOND_ACTIVE_LOW_EN for pull-up (active-low) note buttons.
module key_conditioner
    import keycond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_NOTES-1:0] key_raw,
    input  logic [1:0]           sw_raw,
    output logic [NUM_NOTES-1:0] btn,
    output logic [1:0]           sw,
    output logic [2:0]           note_idx,
    output logic                 press_pulse,
    output logic                 release_pulse
);

    logic [NUM_NOTES-1:0] key_in;
    logic [NUM_NOTES-1:0] kd;
    logic [1:0]           sw_d;
    logic [2:0]           hi;
    arb_state_t           state;

`ifdef KEYCOND_ACTIVE_LOW_EN
    assign key_in = ~key_raw;
`else
    assign key_in = key_raw;
`endif

    for (genvar i = 0; i < NUM_NOTES; i++) begin : g_key
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk  (clk),
            .rst  (rst),
            .din  (key_in[i]),
            .dout (kd[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_sw
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk  (clk),
            .rst  (rst),
            .din  (sw_raw[i]),
            .dout (sw_d[i])
        );
    end

    // Switches bypass the arbiter; the debouncer's stable register is already a flop.
    assign sw = sw_d;

    // NOTE: combinational blocks assign every output unconditionally so no latch is inferred.
    always_comb begin
        hi = top_bit(kd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            btn           <= '0;
            note_idx      <= NOTE_NONE;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (kd != '0) begin
                        btn         <= NUM_NOTES'(1) << hi;
                        note_idx    <= 3'(NUM_NOTES - 1) - hi;
                        press_pulse <= 1'b1;
                        state       <= HELD;
                    end
                end
                HELD: begin
                    // Only the latched key matters; any other key is ignored until release.
                    if ((kd & btn) == '0) begin
                        btn           <= '0;
                        note_idx      <= NOTE_NONE;
                        release_pulse <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with DEBOUNCE_CYCLES=4; vectors drive on the falling edge.
module tb_key_conditioner;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] key_raw;
    logic [1:0] sw_raw;
    logic [6:0] btn;
    logic [1:0] sw;
    logic [2:0] note_idx;
    logic       press_pulse;
    logic       release_pulse;

    always #5 clk = ~clk;

    key_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk           (clk),
        .rst           (rst),
        .key_raw       (key_raw),
        .sw_raw        (sw_raw),
        .btn           (btn),
        .sw            (sw),
        .note_idx      (note_idx),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    typedef struct {
        logic [6:0] key;
        logic [1:0] swi;
        int         cyc;
        logic [6:0] btn;
        logic [2:0] idx;
        logic       prs;
        logic       rel;
        logic [1:0] swo;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   press_cnt = 0;
    int   release_cnt = 0;
    int   both_cnt = 0;
    vec_t exp_q[$];
    vec_t tbl[20];

    always @(negedge clk) begin
        if (press_pulse) press_cnt++;
        if (release_pulse) release_cnt++;
        if (press_pulse && release_pulse) both_cnt++;
    end

    // Logical key pattern to board-level pin levels.
    function automatic logic [6:0] phys(input logic [6:0] k);
`ifdef KEYCOND_ACTIVE_LOW_EN
        return ~k;
`else
        return k;
`endif
    endfunction

    function automatic vec_t mk(input logic [6:0] key, input logic [1:0] swi, input int cyc,
                                input logic [6:0] b, input logic [2:0] idx, input logic prs,
                                input logic rel, input logic [1:0] swo);
        vec_t v;
        v.key = key; v.swi = swi; v.cyc = cyc; v.btn = b;
        v.idx = idx; v.prs = prs; v.rel = rel; v.swo = swo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called on a falling edge: drive, wait v.cyc falling edges, compare against the queued expectation.
    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        key_raw = phys(v.key);
        sw_raw  = v.swi;
        exp_q.push_back(v);
        repeat (v.cyc) @(negedge clk);
        e = exp_q.pop_front();
        check({tag, ".btn"}, 32'(btn), 32'(e.btn));
        check({tag, ".idx"}, 32'(note_idx), 32'(e.idx));
        check({tag, ".press"}, 32'(press_pulse), 32'(e.prs));
        check({tag, ".release"}, 32'(release_pulse), 32'(e.rel));
        check({tag, ".sw"}, 32'(sw), 32'(e.swo));
    endtask

    initial begin
        int p0;
        int r0;
        int bad;

        //               key         sw     cyc btn         idx   p     r     sw out
        tbl[0]  = mk(7'b0000000, 2'b00, 2, 7'b0000000, 3'd7, 1'b0, 1'b0, 2'b00);
        tbl[1]  = mk(7'b1000000, 2'b00, 6, 7'b0000000, 3'd7, 1'b0, 1'b0, 2'b00);
        tbl[2]  = mk(7'b1000000, 2'b00, 1, 7'b1000000, 3'd0, 1'b1, 1'b0, 2'b00);
        tbl[3]  = mk(7'b1000000, 2'b00, 1, 7'b1000000, 3'd0, 1'b0, 1'b0, 2'b00);
        tbl[4]  = mk(7'b1010000, 2'b00, 7, 7'b1000000, 3'd0, 1'b0, 1'b0, 2'b00);
        tbl[5]  = mk(7'b0010000, 2'b00, 6, 7'b1000000, 3'd0, 1'b0, 1'b0, 2'b00);
        tbl[6]  = mk(7'b0010000, 2'b00, 1, 7'b0000000, 3'd7, 1'b0, 1'b1, 2'b00);
        tbl[7]  = mk(7'b0010000, 2'b00, 1, 7'b0010000, 3'd2, 1'b1, 1'b0, 2'b00);
        tbl[8]  = mk(7'b0010000, 2'b00, 1, 7'b0010000, 3'd2, 1'b0, 1'b0, 2'b00);
        tbl[9]  = mk(7'b0000000, 2'b00, 7, 7'b0000000, 3'd7, 1'b0, 1'b1, 2'b00);
        tbl[10] = mk(7'b0000000, 2'b00, 1, 7'b0000000, 3'd7, 1'b0, 1'b0, 2'b00);
        tbl[11] = mk(7'b0000110, 2'b00, 7, 7'b0000100, 3'd4, 1'b1, 1'b0, 2'b00);
        tbl[12] = mk(7'b0000110, 2'b00, 1, 7'b0000100, 3'd4, 1'b0, 1'b0, 2'b00);
        tbl[13] = mk(7'b0000000, 2'b00, 7, 7'b0000000, 3'd7, 1'b0, 1'b1, 2'b00);
        tbl[14] = mk(7'b0000000, 2'b11, 5, 7'b0000000, 3'd7, 1'b0, 1'b0, 2'b00);
        tbl[15] = mk(7'b0000000, 2'b11, 1, 7'b0000000, 3'd7, 1'b0, 1'b0, 2'b11);
        tbl[16] = mk(7'b0000000, 2'b01, 2, 7'b0000000, 3'd7, 1'b0, 1'b0, 2'b11);
        tbl[17] = mk(7'b0000000, 2'b11, 8, 7'b0000000, 3'd7, 1'b0, 1'b0, 2'b11);
        tbl[18] = mk(7'b0000000, 2'b10, 6, 7'b0000000, 3'd7, 1'b0, 1'b0, 2'b10);
        tbl[19] = mk(7'b0000000, 2'b00, 6, 7'b0000000, 3'd7, 1'b0, 1'b0, 2'b00);

        rst     = 1'b1;
        key_raw = phys(7'b0);
        sw_raw  = 2'b00;
        repeat (2) @(negedge clk);
        check("reset.btn", 32'(btn), 32'h0);
        check("reset.idx", 32'(note_idx), 32'd7);
        check("reset.pulses", 32'({press_pulse, release_pulse}), 32'h0);
        check("reset.sw", 32'(sw), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end
        check("table.press_count", 32'(press_cnt), 32'd3);
        check("table.release_count", 32'(release_cnt), 32'd3);

        // Bounce on XI with 3-cycle pulses must never be accepted.
        p0  = press_cnt;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            key_raw = phys(((i / 3) % 2 == 0) ? 7'b0000001 : 7'b0000000);
            @(negedge clk);
            if (btn != 7'b0) bad++;
        end
        check("bounce.btn_nonzero_cycles", 32'(bad), 32'd0);
        check("bounce.press_count", 32'(press_cnt - p0), 32'd0);
        run_vec(mk(7'b0000001, 2'b00, 6, 7'b0000000, 3'd7, 1'b0, 1'b0, 2'b00), "xi_hold_early");
        run_vec(mk(7'b0000001, 2'b00, 1, 7'b0000001, 3'd6, 1'b1, 1'b0, 2'b00), "xi_latch");
        run_vec(mk(7'b0000000, 2'b00, 7, 7'b0000000, 3'd7, 1'b0, 1'b1, 2'b00), "xi_release");

        // Reset while FA is latched: silent clear, then FA re-debounced from scratch.
        run_vec(mk(7'b0001000, 2'b00, 7, 7'b0001000, 3'd3, 1'b1, 1'b0, 2'b00), "fa_latch");
        r0  = release_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid.btn", 32'(btn), 32'h0);
        check("rst_mid.idx", 32'(note_idx), 32'd7);
        check("rst_mid.release", 32'(release_pulse), 32'h0);
        run_vec(mk(7'b0001000, 2'b00, 6, 7'b0000000, 3'd7, 1'b0, 1'b0, 2'b00), "fa_after_rst_early");
        run_vec(mk(7'b0001000, 2'b00, 1, 7'b0001000, 3'd3, 1'b1, 1'b0, 2'b00), "fa_after_rst");
        check("rst_mid.release_count", 32'(release_cnt - r0), 32'd0);

        check("pulse_overlap_count", 32'(both_cnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
